conv_encoder_tx: RTL and testbench
==================================

# conv_encoder_tx

Rate-1/2, constraint-length-3 convolutional encoder and symbol serializer: the transmit-side counterpart of the Viterbi decoder's traceback/output stage. Accepts one byte per frame over a valid/ready handshake, shifts its bits LSB-first through a 2-bit encoder state, and emits one 2-bit code symbol per input bit under downstream backpressure. Its trellis and state encoding are identical to the decoder's, so each frame starts in state 00 and, with tail enabled, ends in state 00.

## Interface
- DATA_W, 8, bits per frame (input byte width)
- G0, 3'b111, generator for o_sym[1], ordered {u, s[1], s[0]}
- G1, 3'b101, generator for o_sym[0], same ordering
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_data  in  DATA_W  frame payload, sampled on accept
- i_valid  in  1  payload valid
- o_ready  out  1  encoder can accept a frame (high only in IDLE)
- o_sym  out  2  code symbol {c0, c1}
- o_sym_valid  out  1  o_sym is valid
- i_sym_ready  in  1  downstream consumes o_sym this cycle
- o_last  out  1  o_sym is the final symbol of the frame
- o_done  out  1  one-cycle pulse after the final symbol is consumed

## Operation
- Encoder state s[1:0] = {newest bit, previous bit}; next state = {u, s[1]}.
- c0 = ^(G0 & {u, s}), c1 = ^(G1 & {u, s}); defaults give c0 = u^s[1]^s[0], c1 = u^s[0].
- FSM states: IDLE, ENCODE, TAIL (only with tail enabled), DONE.
- IDLE: o_ready=1. On i_valid && o_ready: latch i_data into a shift register, clear s to 00, clear bit counter, go to ENCODE.
- ENCODE: u = shift_reg[0]; o_sym_valid=1. On i_sym_ready: update s, shift right, increment counter. After bit DATA_W-1 is consumed, go to TAIL (tail enabled) or DONE.
- TAIL: u = 0 for 2 symbols; same advance rule; after the 2nd tail symbol is consumed, go to DONE. The state is guaranteed to be 00.
- DONE: o_done=1 for exactly one cycle; o_sym_valid=0; return to IDLE.
- o_last=1 with o_sym_valid on the final symbol: bit DATA_W-1, or tail symbol 2 when tail is enabled.
- Counter width is $clog2(DATA_W+2). The counter never wraps within a frame.
- i_valid outside IDLE is ignored; i_data is not re-sampled mid-frame.

## Timing
- Reset values: o_ready=1, o_sym=00, o_sym_valid=0, o_last=0, o_done=0; FSM=IDLE, s=00, counter=0.
- Accept at edge N. The first symbol is valid after edge N, with no combinational input-to-output path.
- With no stall: DATA_W symbols (DATA_W+2 with tail) on consecutive cycles, then o_done for one cycle, then o_ready. The next accept can occur at the earliest DATA_W+2 cycles (DATA_W+4 with tail) after the previous one.
- While i_sym_ready=0: o_sym, o_sym_valid and o_last hold stable. The state and counter do not advance.
- i_sym_ready while o_sym_valid=0 has no effect.
- When rst is asserted mid-frame, all outputs immediately take their reset values and the frame is discarded. Partial frames are never resumed.

## Configuration
- CONV_ENC_TAIL_EN defined: TAIL state compiled in. Two zero flush bits are appended, giving DATA_W+2 symbols per frame, and every frame terminates in state 00, matching the decoder's traceback start.
- CONV_ENC_TAIL_EN undefined: no TAIL state and exactly DATA_W symbols per frame. The final state is data-dependent, but the next frame still starts from 00.

## Structure
- Shared package conv_code_pkg:
  - state encodings S00/S01/S10/S11 (shared with the decoder);
  - default G0/G1 constants;
  - DATA_W default;
  - the FSM state enum.
- One combinational sub-module, conv_branch_symbol:
  - inputs u and s; outputs c0, c1 and the next state;
  - reusable by the decoder's branch-metric unit.
- The top level holds the FSM, shift register, counter and handshake.

## Test plan
- Tail enabled, i_data=8'h01, i_sym_ready=1:
  - symbols 11,10,11,00,00,00,00,00,00,00;
  - o_last on the 10th symbol, o_done on the next cycle, final s=00.
- Tail enabled, i_data=8'hFF:
  - symbols 11,01,10,10,10,10,10,10, then tail 01,11.
- Tail disabled, i_data=8'hFF:
  - symbols 11,01,10,10,10,10,10,10, with o_last on the 8th;
  - a second frame 8'h01 then yields 11,10,11,00,… (state reset between frames).
- Backpressure on 8'h01: hold i_sym_ready=0 for 3 cycles at symbol 2.
  - o_sym=10 and o_sym_valid are held stable throughout the stall;
  - the full sequence is unchanged and o_done is delayed by 3 cycles.
- Handshake: i_valid held high continuously with changing i_data.
  - Only IDLE-cycle values are accepted;
  - o_ready=0 for the entire frame.
- Reset mid-frame: assert rst at symbol 4.
  - All outputs go to their reset values immediately;
  - after release, a new 8'h01 frame produces the correct sequence from 11.

Source files
------------

// File: rtl/conv_code_pkg.sv
// Shared rate-1/2, K=3 convolutional code definitions (encoder and decoder).
// Trellis state s[1:0] = {newest bit, previous bit}; next state = {u, s[1]}.
package conv_code_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Generators ordered {u, s[1], s[0]}
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  // Trellis state encodings shared with the Viterbi decoder
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_TAIL   = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

  // Parity of the generator taps applied to {u, s}
  function automatic logic branch_bit(input logic [2:0] g, input logic u,
                                      input logic [1:0] s);
    return ^(g & {u, s});
  endfunction

endpackage

// File: rtl/conv_branch_symbol.sv
// Combinational trellis branch: code bits and next state for input bit u
// leaving state s. Shared with the decoder's branch-metric unit.
module conv_branch_symbol
  import conv_code_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input  logic       u,
  input  logic [1:0] s,
  output logic       c0_c,
  output logic       c1_c,
  output logic [1:0] s_next_c
);

  // Branch output bits and successor state
  always_comb begin
    c0_c     = branch_bit(G0, u, s);
    c1_c     = branch_bit(G1, u, s);
    s_next_c = {u, s[1]};
  end

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 convolutional encoder and symbol serializer.
// One byte per frame, bits encoded LSB-first, one registered 2-bit symbol
// per input bit under valid/ready backpressure.
// Build option: CONV_ENC_TAIL_EN appends two zero flush bits so every frame
// terminates in state 00.
module conv_encoder_tx
  import conv_code_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter logic [2:0]  G0     = G0_DEF,
  parameter logic [2:0]  G1     = G1_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [1:0]        o_sym,
  output logic              o_sym_valid,
  input  logic              i_sym_ready,
  output logic              o_last,
  output logic              o_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
`ifdef CONV_ENC_TAIL_EN
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(DATA_W + 1);
`endif

  enc_state_e        state_q, state_nx;
  logic [DATA_W-1:0] shreg_q, shreg_nx;
  logic [1:0]        s_q, s_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;

  logic              accept;
  logic              consume;
  logic              u_cur;
  logic              u_nx;
  logic [1:0]        s_adv;
  logic              cur_c0, cur_c1;
  logic              nx_c0, nx_c1;
  logic [1:0]        nx_s_next;
  logic              unused_branch;

  logic [1:0]        sym_nx;
  logic              sym_valid_nx;
  logic              last_nx;
  logic              done_nx;
  logic              ready_nx;

  assign accept  = i_valid && o_ready;
  assign consume = o_sym_valid && i_sym_ready;

  // Input bit of the symbol currently presented, and of the one presented next
  assign u_cur = (state_q == ST_ENCODE) && shreg_q[0];
  assign u_nx  = (state_nx == ST_ENCODE) && shreg_nx[0];

  // Branch for the current symbol: gives the state after it is consumed
  conv_branch_symbol #(.G0(G0), .G1(G1)) u_branch_cur (
    .u        (u_cur),
    .s        (s_q),
    .c0_c     (cur_c0),
    .c1_c     (cur_c1),
    .s_next_c (s_adv)
  );

  // Branch for the next symbol: gives the code bits to register
  conv_branch_symbol #(.G0(G0), .G1(G1)) u_branch_nx (
    .u        (u_nx),
    .s        (s_nx),
    .c0_c     (nx_c0),
    .c1_c     (nx_c1),
    .s_next_c (nx_s_next)
  );

  assign unused_branch = ^{cur_c0, cur_c1, nx_s_next};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_nx = ST_ENCODE;
      end
      ST_ENCODE: begin
        if (consume && (cnt_q == LAST_DATA)) begin
`ifdef CONV_ENC_TAIL_EN
          state_nx = ST_TAIL;
`else
          state_nx = ST_DONE;
`endif
        end
      end
`ifdef CONV_ENC_TAIL_EN
      ST_TAIL: begin
        if (consume && (cnt_q == LAST_TAIL)) state_nx = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: load on accept, advance one bit per consumed symbol
  always_comb begin
    shreg_nx = shreg_q;
    s_nx     = s_q;
    cnt_nx   = cnt_q;
    if (accept) begin
      shreg_nx = i_data;
      s_nx     = S00;
      cnt_nx   = '0;
    end else if (consume) begin
      shreg_nx = shreg_q >> 1;
      s_nx     = s_adv;
      cnt_nx   = cnt_q + CNT_W'(1);
    end
  end

  // Output logic: next values of the registered outputs, from the next state
  always_comb begin
    sym_nx       = 2'b00;
    sym_valid_nx = 1'b0;
    last_nx      = 1'b0;
    done_nx      = 1'b0;
    ready_nx     = 1'b0;
    case (state_nx)
      ST_IDLE: begin
        ready_nx = 1'b1;
      end
      ST_ENCODE: begin
        sym_valid_nx = 1'b1;
        sym_nx       = {nx_c0, nx_c1};
`ifndef CONV_ENC_TAIL_EN
        last_nx      = (cnt_nx == LAST_DATA);
`endif
      end
`ifdef CONV_ENC_TAIL_EN
      ST_TAIL: begin
        sym_valid_nx = 1'b1;
        sym_nx       = {nx_c0, nx_c1};
        last_nx      = (cnt_nx == LAST_TAIL);
      end
`endif
      ST_DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        ready_nx = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q     <= '0;
      s_q         <= S00;
      cnt_q       <= '0;
      o_ready     <= 1'b1;
      o_sym       <= 2'b00;
      o_sym_valid <= 1'b0;
      o_last      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      shreg_q     <= shreg_nx;
      s_q         <= s_nx;
      cnt_q       <= cnt_nx;
      o_ready     <= ready_nx;
      o_sym       <= sym_nx;
      o_sym_valid <= sym_valid_nx;
      o_last      <= last_nx;
      o_done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx; expectations follow CONV_ENC_TAIL_EN.
module tb_conv_encoder_tx;

`ifdef CONV_ENC_TAIL_EN
  localparam int NSYM = 10;
`else
  localparam int NSYM = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] o_sym;
  logic       o_sym_valid;
  logic       i_sym_ready;
  logic       o_last;
  logic       o_done;

  int n_cmp;
  int n_fail;

  // Hand-derived symbol tables {c0,c1}; entries 8 and 9 are the tail symbols
  logic [1:0] exp_01 [10] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] exp_ff [10] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
  logic [1:0] exp_a5 [10] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11};

  logic [1:0] got_sym  [16];
  logic       got_last [16];
  logic [1:0] stall_sym [4];
  int got_n;
  int done_cyc;
  int first_cyc;
  int ready_hi;

  conv_encoder_tx dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_sym       (o_sym),
    .o_sym_valid (o_sym_valid),
    .i_sym_ready (i_sym_ready),
    .o_last      (o_last),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send one frame starting at a falling edge and capture its symbols.
  // Optional stall before symbol index stall_at; hold_valid keeps i_valid high
  // and scrambles i_data every cycle. Returns at the falling edge after o_done.
  task automatic run_frame(input logic [7:0] d, input int stall_at,
                           input int stall_len, input bit hold_valid);
    int cyc;
    int rem;
    rem = stall_len;
    got_n = 0;
    done_cyc = -1;
    first_cyc = -1;
    ready_hi = 0;
    for (int i = 0; i < 16; i++) begin
      got_sym[i] = 2'bxx;
      got_last[i] = 1'bx;
    end
    i_valid = 1'b1;
    i_data = d;
    i_sym_ready = 1'b1;
    @(negedge clk);
    if (!hold_valid) i_valid = 1'b0;
    cyc = 0;
    while (done_cyc < 0 && cyc < 200) begin
      if (hold_valid) i_data = d ^ 8'(cyc + 1);
      if (o_ready) ready_hi++;
      if (o_done) begin
        done_cyc = cyc;
      end else if (o_sym_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (got_n == stall_at && rem > 0) begin
          stall_sym[stall_len - rem] = o_sym;
          i_sym_ready = 1'b0;
          rem--;
        end else begin
          i_sym_ready = 1'b1;
          if (got_n < 16) begin
            got_sym[got_n] = o_sym;
            got_last[got_n] = o_last;
          end
          got_n++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    i_sym_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_valid = 1'b0;
    i_data = 8'h00;
    i_sym_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_sym !== 2'b00) begin n_fail++; $display("FAIL reset_sym got=%b exp=00", o_sym); end
    n_cmp++; if (o_sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sym_valid got=%b exp=0", o_sym_valid); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", o_last); end
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", o_done); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_sym_valid !== 1'b0) begin n_fail++; $display("FAIL idle_sym_ready_no_effect got=%b exp=0", o_sym_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_frame_01();
    run_frame(8'h01, -1, 0, 1'b0);
    n_cmp++; if (first_cyc !== 0) begin n_fail++; $display("FAIL f01_first_latency got=%0d exp=0", first_cyc); end
    n_cmp++; if (got_n !== NSYM) begin n_fail++; $display("FAIL f01_count got=%0d exp=%0d", got_n, NSYM); end
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_01[i]) begin n_fail++; $display("FAIL f01_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_01[i]); end
      n_cmp++; if (got_last[i] !== 1'(i == NSYM - 1)) begin n_fail++; $display("FAIL f01_last[%0d] got=%b exp=%b", i, got_last[i], 1'(i == NSYM - 1)); end
    end
    n_cmp++; if (done_cyc !== NSYM) begin n_fail++; $display("FAIL f01_done_cycle got=%0d exp=%0d", done_cyc, NSYM); end
    n_cmp++; if (ready_hi !== 0) begin n_fail++; $display("FAIL f01_ready_in_frame got=%0d exp=0", ready_hi); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL f01_ready_after_done got=%b exp=1", o_ready); end
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL f01_done_single_pulse got=%b exp=0", o_done); end
`ifdef CONV_ENC_TAIL_EN
    n_cmp++; if (dut.s_q !== 2'b00) begin n_fail++; $display("FAIL f01_final_state got=%b exp=00", dut.s_q); end
`endif
  endtask

  task automatic test_frame_ff_then_01();
    run_frame(8'hFF, -1, 0, 1'b0);
    n_cmp++; if (got_n !== NSYM) begin n_fail++; $display("FAIL fff_count got=%0d exp=%0d", got_n, NSYM); end
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_ff[i]) begin n_fail++; $display("FAIL fff_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_ff[i]); end
      n_cmp++; if (got_last[i] !== 1'(i == NSYM - 1)) begin n_fail++; $display("FAIL fff_last[%0d] got=%b exp=%b", i, got_last[i], 1'(i == NSYM - 1)); end
    end
`ifdef CONV_ENC_TAIL_EN
    n_cmp++; if (dut.s_q !== 2'b00) begin n_fail++; $display("FAIL fff_final_state got=%b exp=00", dut.s_q); end
`else
    n_cmp++; if (dut.s_q !== 2'b11) begin n_fail++; $display("FAIL fff_final_state got=%b exp=11", dut.s_q); end
`endif
    run_frame(8'h01, -1, 0, 1'b0);
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_01[i]) begin n_fail++; $display("FAIL f01_after_ff_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_01[i]); end
    end
  endtask

  task automatic test_frame_a5();
    run_frame(8'hA5, -1, 0, 1'b0);
    n_cmp++; if (got_n !== NSYM) begin n_fail++; $display("FAIL fa5_count got=%0d exp=%0d", got_n, NSYM); end
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_a5[i]) begin n_fail++; $display("FAIL fa5_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_a5[i]); end
    end
    n_cmp++; if (done_cyc !== NSYM) begin n_fail++; $display("FAIL fa5_done_cycle got=%0d exp=%0d", done_cyc, NSYM); end
  endtask

  task automatic test_backpressure();
    run_frame(8'h01, 1, 3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (stall_sym[k] !== 2'b10) begin n_fail++; $display("FAIL bp_hold_sym[%0d] got=%b exp=10", k, stall_sym[k]); end
    end
    n_cmp++; if (got_n !== NSYM) begin n_fail++; $display("FAIL bp_count got=%0d exp=%0d", got_n, NSYM); end
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_01[i]) begin n_fail++; $display("FAIL bp_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_01[i]); end
    end
    n_cmp++; if (done_cyc !== NSYM + 3) begin n_fail++; $display("FAIL bp_done_cycle got=%0d exp=%0d", done_cyc, NSYM + 3); end
  endtask

  task automatic test_handshake();
    run_frame(8'h01, -1, 0, 1'b1);
    n_cmp++; if (ready_hi !== 0) begin n_fail++; $display("FAIL hs_ready_in_frame got=%0d exp=0", ready_hi); end
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_01[i]) begin n_fail++; $display("FAIL hs_first_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_01[i]); end
    end
    run_frame(8'hA5, -1, 0, 1'b1);
    i_valid = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_a5[i]) begin n_fail++; $display("FAIL hs_second_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_a5[i]); end
    end
    n_cmp++; if (done_cyc !== NSYM) begin n_fail++; $display("FAIL hs_done_cycle got=%0d exp=%0d", done_cyc, NSYM); end
  endtask

  task automatic test_reset_mid_frame();
    i_valid = 1'b1;
    i_data = 8'hFF;
    i_sym_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_sym !== 2'b10) begin n_fail++; $display("FAIL rmf_sym4_before_reset got=%b exp=10", o_sym); end
    rst = 1'b0;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_ready got=%b exp=1", o_ready); end
    n_cmp++; if (o_sym !== 2'b00) begin n_fail++; $display("FAIL rmf_sym got=%b exp=00", o_sym); end
    n_cmp++; if (o_sym_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_sym_valid got=%b exp=0", o_sym_valid); end
    n_cmp++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL rmf_last got=%b exp=0", o_last); end
    n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rmf_done got=%b exp=0", o_done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(8'h01, -1, 0, 1'b0);
    n_cmp++; if (got_n !== NSYM) begin n_fail++; $display("FAIL rmf_new_count got=%0d exp=%0d", got_n, NSYM); end
    for (int i = 0; i < NSYM; i++) begin
      n_cmp++; if (got_sym[i] !== exp_01[i]) begin n_fail++; $display("FAIL rmf_new_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_01[i]); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_frame_01();
    test_frame_ff_then_01();
    test_frame_a5();
    test_backpressure();
    test_handshake();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
